// File: rtl/issue_ctrl_pkg.sv
// Shared types and constants for the dual-slot issue controller.
package issue_ctrl_pkg;

  localparam int SB_POS_W = 3;
  localparam int REG_AW   = 5;
  localparam int MD_CNT_W = 6;

  typedef logic [REG_AW-1:0] REG_ADDR;

  // Scoreboard entry: position of the in-flight producer in the pipeline.
  // Positions 0 and 1 mean "absent" or "forwardable".
  typedef struct packed {
    logic [SB_POS_W-1:0] position;
  } SCORE_BOARD_DATA;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/issue_ctrl_if.sv
// Candidate/issue and scoreboard bundle between the front end (master)
// and the issue controller (slave).
//
// Handshake: inst_valid[i] offers candidate i (slot 0 is older); issue[i]
// is the same-cycle acceptance, and the candidate is consumed at the next
// rising edge. A candidate that is not issued stays offered. issue[1] is
// never asserted without issue[0]. Scoreboard reads are combinational:
// sb_data answers sb_read_addr in the same cycle.
interface issue_ctrl_if;
  import issue_ctrl_pkg::*;

  logic [1:0]           inst_valid;
  logic [1:0]           inst_wr;
  REG_ADDR [1:0]        inst_dst;
  REG_ADDR [3:0]        inst_src;
  SCORE_BOARD_DATA [1:0] inst_pos;
  logic [1:0]           inst_md;
  logic [1:0]           issue;

  REG_ADDR [3:0]        sb_read_addr;
  SCORE_BOARD_DATA [3:0] sb_data;
  logic [1:0]           sb_write_ena;
  REG_ADDR [1:0]        sb_write_addr;
  SCORE_BOARD_DATA [1:0] sb_data_out;

  modport master (
    output inst_valid, inst_wr, inst_dst, inst_src, inst_pos, inst_md, sb_data,
    input  issue, sb_read_addr, sb_write_ena, sb_write_addr, sb_data_out
  );

  modport slave (
    input  inst_valid, inst_wr, inst_dst, inst_src, inst_pos, inst_md, sb_data,
    output issue, sb_read_addr, sb_write_ena, sb_write_addr, sb_data_out
  );

endinterface

// File: rtl/issue_ctrl_hazard_check.sv
// Operand readiness for one issue slot: both sources must be either r0
// or held by a producer that is absent or able to forward.
module hazard_check
  import issue_ctrl_pkg::*;
#(
  parameter int SB_POS_W = issue_ctrl_pkg::SB_POS_W
) (
  input  REG_ADDR [1:0]         src,
  input  SCORE_BOARD_DATA [1:0] data,
  output logic                  ready
);

  logic [1:0] op_ready;
  logic       unused_pos_lsb;

  // Per operand: r0 never waits; otherwise only positions 0/1 are usable.
  always_comb begin
    op_ready = '0;
    for (int k = 0; k < 2; k++) begin
      op_ready[k] = (src[k] == '0) || (data[k].position[SB_POS_W-1:1] == '0);
    end
  end

  assign ready = &op_ready;

  // Position bit 0 only distinguishes absent from forwardable.
  assign unused_pos_lsb = ^{data[0].position[0], data[1].position[0]};

endmodule

// File: rtl/issue_ctrl.sv
// Dual-slot in-order issue controller with a shared multi-cycle mul/div
// unit. Issue and scoreboard writes are combinational; only the mul/div
// occupancy FSM is registered. Define ISSUE_DUAL_EN to enable slot 1;
// the default build issues at most one instruction per cycle.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int MD_LAT   = 32,
  parameter int SB_POS_W = issue_ctrl_pkg::SB_POS_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  issue_ctrl_if.slave bus,
  output logic        md_busy,
  output md_state_t   md_state
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

  logic [MD_CNT_W-1:0] md_cnt;
  logic                run;
  logic                ready0;
  logic [1:0]          issue_c;
  logic [1:0]          sb_we;
  logic                md_issue;

  hazard_check #(.SB_POS_W(SB_POS_W)) u_hc0 (
    .src   (bus.inst_src[1:0]),
    .data  (bus.sb_data[1:0]),
    .ready (ready0)
  );

`ifdef ISSUE_DUAL_EN
  logic ready1;
  logic raw;

  hazard_check #(.SB_POS_W(SB_POS_W)) u_hc1 (
    .src   (bus.inst_src[3:2]),
    .data  (bus.sb_data[3:2]),
    .ready (ready1)
  );

  // Slot 1 may not read what the older slot writes in the same pair.
  assign raw = bus.inst_wr[0] && (bus.inst_dst[0] != '0) &&
               ((bus.inst_src[2] == bus.inst_dst[0]) ||
                (bus.inst_src[3] == bus.inst_dst[0]));
`else
  logic unused_slot1;
  assign unused_slot1 = ^{bus.inst_valid[1], bus.sb_data[3], bus.sb_data[2]};
`endif

  // In-order issue decision; run keeps issue off until the first edge
  // after reset release.
  always_comb begin
    issue_c    = '0;
    issue_c[0] = run & bus.inst_valid[0] & ready0 &
                 ~(bus.inst_md[0] & md_busy) & ~stall & ~flush;
`ifdef ISSUE_DUAL_EN
    issue_c[1] = issue_c[0] & bus.inst_valid[1] & ready1 &
                 ~(bus.inst_md[1] & (md_busy | bus.inst_md[0])) & ~raw;
`endif
  end

  // Scoreboard writes follow issue; r0 is never tracked.
  always_comb begin
    sb_we = '0;
    for (int i = 0; i < 2; i++) begin
      sb_we[i] = issue_c[i] & bus.inst_wr[i] & (bus.inst_dst[i] != '0);
    end
  end

  assign md_issue          = |(issue_c & bus.inst_md);
  assign bus.issue         = issue_c;
  assign bus.sb_write_ena  = sb_we;
  assign bus.sb_write_addr = bus.inst_dst;
  assign bus.sb_data_out   = bus.inst_pos;
  assign bus.sb_read_addr  = bus.inst_src;

  // Mul/div occupancy FSM: MD_LAT busy cycles per issued md op, counter
  // runs through stalls, flush abandons the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state <= IDLE;
      md_cnt   <= '0;
      md_busy  <= 1'b0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        md_state <= IDLE;
        md_cnt   <= '0;
        md_busy  <= 1'b0;
      end else begin
        case (md_state)
          IDLE: begin
            if (md_issue) begin
              md_state <= BUSY;
              md_cnt   <= MD_LOAD;
              md_busy  <= 1'b1;
            end
          end
          BUSY: begin
            if (md_cnt == '0) begin
              md_state <= IDLE;
              md_busy  <= 1'b0;
            end else begin
              md_cnt <= md_cnt - 1'b1;
            end
          end
          default: begin
            md_state <= IDLE;
            md_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
